// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps at most one imem request in flight,
// holds a returned instruction across front-end stalls and drops stale responses after redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_f,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        fetch_valid,
    output logic [31:0] fetch_addr,
    output logic [31:0] fetch_inst,
    output logic        fetch_busy
);
    typedef enum logic [1:0] {ISSUE, WAIT, HOLD, DROP} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] hold_buf;
    logic [31:0] target;

    assign target = {redirect_pc[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ISSUE;
            pc       <= RESET_PC;
            hold_buf <= '0;
        end else begin
            case (state)
                ISSUE: begin
                    if (redirect) pc <= target;
                    else          state <= WAIT;
                end
                WAIT: begin
                    if (redirect) begin
                        pc    <= target;
                        // A response landing with the redirect is dropped right here;
                        // otherwise it is still outstanding and must be swallowed later.
                        state <= imem_rvalid ? ISSUE : DROP;
                    end else if (imem_rvalid) begin
                        if (stall_f) begin
                            hold_buf <= imem_rdata;
                            state    <= HOLD;
                        end else begin
                            pc    <= pc + 32'd4;
                            state <= ISSUE;
                        end
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc    <= target;
                        state <= ISSUE;
                    end else if (!stall_f) begin
                        pc    <= pc + 32'd4;
                        state <= ISSUE;
                    end
                end
                DROP: begin
                    if (redirect) pc <= target;
                    if (imem_rvalid) state <= ISSUE;
                end
                default: state <= ISSUE;
            endcase
        end
    end

    assign imem_req    = (state == ISSUE) && !redirect;
    assign imem_addr   = pc;
    assign fetch_valid = ((state == WAIT) && imem_rvalid && !redirect) ||
                         ((state == HOLD) && !redirect);
    assign fetch_addr  = pc;
    assign fetch_inst  = fetch_valid ? ((state == HOLD) ? hold_buf : imem_rdata) : NOP_INST;
    assign fetch_busy  = !fetch_valid;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against a
// transaction-level model of program order, request occupancy and stalls.
module tb_fetch_unit;
    localparam logic [31:0] RPC = 32'hFFFF_FFFC;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_f;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        fetch_valid;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_inst;
    logic        fetch_busy;

    fetch_unit #(.RESET_PC(RPC), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst), .stall_f(stall_f), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .fetch_valid(fetch_valid), .fetch_addr(fetch_addr),
        .fetch_inst(fetch_inst), .fetch_busy(fetch_busy)
    );

    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;

    // memory model: one slot for the in-flight request
    logic        pending;
    int          cnt;
    logic [31:0] p_addr;
    logic        p_stale;
    int          overlap;
    logic        was_out;
    logic        d_stale;

    // values sampled mid-cycle
    logic        s_req, s_valid, s_busy, s_rvalid;
    logic [31:0] s_addr, s_faddr, s_inst;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hA5A5_0093 ^ {a[15:0], a[31:16]};
    endfunction

    task automatic do_reset();
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; stall_f = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        pending = 1'b0; cnt = 0; p_addr = '0; p_stale = 1'b0; overlap = 0;
    endtask

    // One clock of stimulus: memory answers, inputs driven, outputs sampled, memory accepts.
    task automatic cycle(input logic rd, input logic [31:0] rpc, input logic st, input int lat);
        was_out = pending;
        d_stale = 1'b0;
        if (pending && cnt == 0) begin
            imem_rvalid = 1'b1; imem_rdata = memf(p_addr); d_stale = p_stale; pending = 1'b0;
        end else begin
            imem_rvalid = 1'b0; imem_rdata = $urandom;
            if (pending) cnt--;
        end
        redirect = rd; redirect_pc = rpc; stall_f = st;
        #1;
        s_req = imem_req; s_addr = imem_addr; s_valid = fetch_valid;
        s_faddr = fetch_addr; s_inst = fetch_inst; s_busy = fetch_busy; s_rvalid = imem_rvalid;
        if ((rd || rst) && pending) p_stale = 1'b1;
        if (s_req && !rst) begin
            if (pending) overlap++;
            pending = 1'b1; cnt = lat - 1; p_addr = s_addr; p_stale = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b0, '0, 1'b0, 1);
        ntests++; if (s_req !== 1'b1) begin nfail++; $display("FAIL reset_req got %h exp 1", s_req); end
        ntests++; if (s_addr !== RPC) begin nfail++; $display("FAIL reset_addr got %h exp %h", s_addr, RPC); end
        ntests++; if (s_valid !== 1'b0) begin nfail++; $display("FAIL reset_valid got %h exp 0", s_valid); end
        ntests++; if (s_inst !== NOP) begin nfail++; $display("FAIL reset_inst got %h exp %h", s_inst, NOP); end
        ntests++; if (s_busy !== 1'b1) begin nfail++; $display("FAIL reset_busy got %h exp 1", s_busy); end
    endtask

    // consume RESET_PC (wraps to 0), then 0x0 and 0x4 at two cycles each
    task automatic test_wrap_seq();
        logic [31:0] a;
        for (int k = 0; k < 3; k++) begin
            a = RPC + 32'(4 * k);
            if (k > 0) begin
                cycle(1'b0, '0, 1'b0, 1);
                ntests++; if (s_req !== 1'b1 || s_addr !== a) begin nfail++; $display("FAIL seq_req got %h/%h exp 1/%h", s_req, s_addr, a); end
                ntests++; if (s_inst !== NOP) begin nfail++; $display("FAIL seq_bubble got %h exp %h", s_inst, NOP); end
            end
            cycle(1'b0, '0, 1'b0, 1);
            ntests++; if (s_valid !== 1'b1 || s_faddr !== a) begin nfail++; $display("FAIL seq_valid got %h/%h exp 1/%h", s_valid, s_faddr, a); end
            ntests++; if (s_inst !== memf(a)) begin nfail++; $display("FAIL seq_inst got %h exp %h", s_inst, memf(a)); end
            ntests++; if (s_req !== 1'b0) begin nfail++; $display("FAIL seq_noreq got %h exp 0", s_req); end
        end
    endtask

    task automatic test_stall_hold();
        cycle(1'b0, '0, 1'b0, 1);
        ntests++; if (s_req !== 1'b1 || s_addr !== 32'h8) begin nfail++; $display("FAIL hold_req got %h/%h exp 1/8", s_req, s_addr); end
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, '0, (k < 3), 1);
            ntests++; if (s_valid !== 1'b1 || s_faddr !== 32'h8) begin nfail++; $display("FAIL hold_valid got %h/%h exp 1/8", s_valid, s_faddr); end
            ntests++; if (s_inst !== memf(32'h8)) begin nfail++; $display("FAIL hold_inst got %h exp %h", s_inst, memf(32'h8)); end
            ntests++; if (s_req !== 1'b0) begin nfail++; $display("FAIL hold_noreq got %h exp 0", s_req); end
        end
        cycle(1'b0, '0, 1'b0, 1);
        ntests++; if (s_req !== 1'b1 || s_addr !== 32'hC) begin nfail++; $display("FAIL hold_next got %h/%h exp 1/c", s_req, s_addr); end
        cycle(1'b0, '0, 1'b0, 1);
        ntests++; if (s_valid !== 1'b1 || s_faddr !== 32'hC) begin nfail++; $display("FAIL hold_after got %h/%h exp 1/c", s_valid, s_faddr); end
    endtask

    task automatic test_redirect_wait();
        cycle(1'b0, '0, 1'b0, 3);
        ntests++; if (s_req !== 1'b1 || s_addr !== 32'h10) begin nfail++; $display("FAIL rw_req got %h/%h exp 1/10", s_req, s_addr); end
        cycle(1'b1, 32'h100, 1'b0, 1);
        ntests++; if (s_valid !== 1'b0 || s_req !== 1'b0) begin nfail++; $display("FAIL rw_redir got %h/%h exp 0/0", s_valid, s_req); end
        for (int k = 0; k < 2; k++) begin
            cycle(1'b0, '0, 1'b0, 1);
            ntests++; if (s_valid !== 1'b0 || s_req !== 1'b0) begin nfail++; $display("FAIL rw_drop got %h/%h exp 0/0", s_valid, s_req); end
        end
        cycle(1'b0, '0, 1'b0, 1);
        ntests++; if (s_req !== 1'b1 || s_addr !== 32'h100) begin nfail++; $display("FAIL rw_target got %h/%h exp 1/100", s_req, s_addr); end
        cycle(1'b0, '0, 1'b0, 1);
        ntests++; if (s_valid !== 1'b1 || s_inst !== memf(32'h100)) begin nfail++; $display("FAIL rw_fetch got %h/%h exp 1/%h", s_valid, s_inst, memf(32'h100)); end
    endtask

    task automatic test_redirect_rvalid();
        cycle(1'b0, '0, 1'b0, 2);
        ntests++; if (s_req !== 1'b1 || s_addr !== 32'h104) begin nfail++; $display("FAIL rr_req got %h/%h exp 1/104", s_req, s_addr); end
        cycle(1'b0, '0, 1'b0, 1);
        cycle(1'b1, 32'h203, 1'b0, 1);
        ntests++; if (s_rvalid !== 1'b1 || s_valid !== 1'b0) begin nfail++; $display("FAIL rr_valid got %h/%h exp 1/0", s_rvalid, s_valid); end
        ntests++; if (s_inst !== NOP) begin nfail++; $display("FAIL rr_inst got %h exp %h", s_inst, NOP); end
        cycle(1'b0, '0, 1'b0, 1);
        ntests++; if (s_req !== 1'b1 || s_addr !== 32'h200) begin nfail++; $display("FAIL rr_target got %h/%h exp 1/200", s_req, s_addr); end
        cycle(1'b0, '0, 1'b0, 1);
    endtask

    task automatic test_drop_double();
        cycle(1'b0, '0, 1'b0, 4);
        ntests++; if (s_req !== 1'b1 || s_addr !== 32'h204) begin nfail++; $display("FAIL dd_req got %h/%h exp 1/204", s_req, s_addr); end
        cycle(1'b1, 32'h40, 1'b0, 1);
        cycle(1'b1, 32'h80, 1'b1, 1);
        ntests++; if (s_req !== 1'b0) begin nfail++; $display("FAIL dd_noreq1 got %h exp 0", s_req); end
        cycle(1'b0, '0, 1'b1, 1);
        ntests++; if (s_req !== 1'b0) begin nfail++; $display("FAIL dd_noreq2 got %h exp 0", s_req); end
        cycle(1'b0, '0, 1'b0, 1);
        ntests++; if (s_rvalid !== 1'b1 || s_valid !== 1'b0 || s_req !== 1'b0) begin nfail++; $display("FAIL dd_stale got %h/%h/%h exp 1/0/0", s_rvalid, s_valid, s_req); end
        cycle(1'b0, '0, 1'b0, 1);
        ntests++; if (s_req !== 1'b1 || s_addr !== 32'h80) begin nfail++; $display("FAIL dd_target got %h/%h exp 1/80", s_req, s_addr); end
        ntests++; if (overlap !== 0) begin nfail++; $display("FAIL dd_outstanding got %0d exp 0", overlap); end
        cycle(1'b0, '0, 1'b0, 1);
    endtask

    task automatic test_reset_in_wait();
        cycle(1'b0, '0, 1'b0, 2);
        ntests++; if (s_req !== 1'b1 || s_addr !== 32'h84) begin nfail++; $display("FAIL rst_req got %h/%h exp 1/84", s_req, s_addr); end
        rst = 1'b1;
        cycle(1'b0, '0, 1'b0, 1);
        rst = 1'b0;
        cycle(1'b0, '0, 1'b0, 1);
        ntests++; if (s_req !== 1'b1 || s_addr !== RPC) begin nfail++; $display("FAIL rst_reissue got %h/%h exp 1/%h", s_req, s_addr, RPC); end
        ntests++; if (s_rvalid !== 1'b1 || s_valid !== 1'b0) begin nfail++; $display("FAIL rst_ignore got %h/%h exp 1/0", s_rvalid, s_valid); end
        cycle(1'b0, '0, 1'b0, 1);
        ntests++; if (s_valid !== 1'b1 || s_inst !== memf(RPC)) begin nfail++; $display("FAIL rst_fetch got %h/%h exp 1/%h", s_valid, s_inst, memf(RPC)); end
    endtask

    // Model: presented instructions follow program order (pc+4, or the latest
    // redirect target), a stalled instruction is re-presented, and a request goes
    // out exactly when nothing is outstanding, nothing is held and no redirect.
    task automatic test_random();
        logic [31:0] exp_pc = 32'h0;
        logic        held = 1'b0;
        logic        rd, st, exp_valid, exp_req;
        logic [31:0] r, rpc;
        int          consumed = 0;
        overlap = 0;
        for (int i = 0; i < 3000; i++) begin
            rd = ($urandom_range(0, 9) == 0);
            st = ($urandom_range(0, 2) == 0);
            r  = $urandom;
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | {28'h0, r[3:0]}) : r;
            cycle(rd, rpc, st, int'($urandom_range(1, 4)));
            exp_valid = !rd && (held || (s_rvalid && !d_stale));
            exp_req   = !rd && !was_out && !held;
            ntests++; if (s_valid !== exp_valid) begin nfail++; $display("FAIL rnd_valid cyc %0d got %h exp %h", i, s_valid, exp_valid); end
            ntests++; if (s_busy !== !exp_valid) begin nfail++; $display("FAIL rnd_busy cyc %0d got %h exp %h", i, s_busy, !exp_valid); end
            ntests++; if (s_req !== exp_req) begin nfail++; $display("FAIL rnd_req cyc %0d got %h exp %h", i, s_req, exp_req); end
            if (exp_req) begin
                ntests++; if (s_addr !== exp_pc) begin nfail++; $display("FAIL rnd_addr cyc %0d got %h exp %h", i, s_addr, exp_pc); end
            end
            if (exp_valid) begin
                ntests++; if (s_faddr !== exp_pc || s_inst !== memf(exp_pc)) begin nfail++; $display("FAIL rnd_fetch cyc %0d got %h/%h exp %h/%h", i, s_faddr, s_inst, exp_pc, memf(exp_pc)); end
            end else begin
                ntests++; if (s_inst !== NOP) begin nfail++; $display("FAIL rnd_nop cyc %0d got %h exp %h", i, s_inst, NOP); end
            end
            if (rd) begin
                exp_pc = {rpc[31:2], 2'b00};
                held   = 1'b0;
            end else if (exp_valid) begin
                held = st;
                if (!st) begin
                    exp_pc = exp_pc + 32'd4;
                    consumed++;
                end
            end
        end
        ntests++; if (overlap !== 0) begin nfail++; $display("FAIL rnd_outstanding got %0d exp 0", overlap); end
        ntests++; if (consumed < 100) begin nfail++; $display("FAIL rnd_progress got %0d exp >=100", consumed); end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_wrap_seq();
        test_stall_hold();
        test_redirect_wait();
        test_redirect_rvalid();
        test_drop_double();
        test_reset_in_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage: owns the PC, issues single-outstanding requests to instruction memory, and presents `fetch_addr`/`fetch_inst` for the IF/ID pipeline register to capture.
- Tolerates variable memory latency, holds a returned instruction while the front end is stalled, and discards stale responses after a branch/jump redirect.
- Produces a NOP (`addi x0,x0,0`) on `fetch_inst` whenever no valid instruction is available, so downstream sees a bubble.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, instruction driven when `fetch_valid`=0.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- stall_f  input  1  IF/ID will not capture this cycle; hold the current instruction.
- redirect  input  1  taken branch/jump from execute; overrides everything except rst.
- redirect_pc  input  32  target PC; bits [1:0] ignored and treated as 0.
- imem_req  output  1  request strobe, one cycle per request, always accepted.
- imem_addr  output  32  request address, word aligned.
- imem_rvalid  input  1  response valid, one cycle, at least 1 cycle after imem_req.
- imem_rdata  input  32  response instruction.
- fetch_valid  output  1  fetch_addr/fetch_inst hold a real instruction this cycle.
- fetch_addr  output  32  PC of presented instruction.
- fetch_inst  output  32  instruction, or NOP_INST when fetch_valid=0.
- fetch_busy  output  1  ~fetch_valid; informs the hazard unit that fetch is waiting.

Behaviour:
- State register (4 states): ISSUE, WAIT, HOLD, DROP. Registers: pc[31:0], hold_buf[31:0].
- Reset (sync, rst=1): pc=RESET_PC, state=ISSUE, hold_buf=0. rst dominates redirect and rvalid. Any in-flight response arriving after reset deasserts is ignored, because state is ISSUE, not WAIT.
- Outputs are combinational from state/inputs:
  - imem_req = (state==ISSUE) & ~redirect.
  - imem_addr = pc.
  - fetch_valid = (state==WAIT & imem_rvalid & ~redirect) | (state==HOLD & ~redirect).
  - fetch_addr = pc.
  - fetch_inst = fetch_valid ? (state==HOLD ? hold_buf : imem_rdata) : NOP_INST.
- ISSUE:
  - redirect: pc<={redirect_pc[31:2],2'b00}; stay ISSUE; no request issued.
  - otherwise: request issued; go to WAIT.
- WAIT:
  - redirect & imem_rvalid: drop the response; load pc from redirect_pc; go to ISSUE.
  - redirect & ~imem_rvalid: load pc from redirect_pc; go to DROP.
  - imem_rvalid & ~stall_f: instruction consumed; pc<=pc+4; go to ISSUE.
  - imem_rvalid & stall_f: hold_buf<=imem_rdata; go to HOLD; pc unchanged.
  - none: stay WAIT.
- HOLD:
  - redirect: load pc from redirect_pc; go to ISSUE.
  - ~stall_f: pc<=pc+4; go to ISSUE.
  - else: stay HOLD; outputs stable.
- DROP (stale response outstanding):
  - redirect: update pc from redirect_pc. Next state is ISSUE if imem_rvalid, else stay DROP.
  - imem_rvalid: discard; go to ISSUE.
  - else: stay DROP.
  - No imem_req is issued in DROP; at most one outstanding request always holds.
- pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
- Throughput: minimum 2 cycles per instruction (ISSUE, WAIT) with 1-cycle memory latency.
- stall_f in ISSUE or DROP has no effect.

Test Plan:
- Reset then 1-cycle memory returning 32'h00500093 at 0x0 and 32'h00108113 at 0x4, no stall:
  - imem_req at cycles 1 and 3.
  - fetch_valid pulses with addr 0x0 then 0x4.
  - fetch_inst is 32'h13 in all other cycles.
- Response 32'h00A00193 arrives with stall_f=1 for 3 cycles:
  - fetch_valid stays 1 with the same addr/inst for all 3 cycles and on the first unstalled cycle.
  - pc advances by 4 only after stall_f drops.
  - No new imem_req during HOLD.
- redirect=1, redirect_pc=0x100 while in WAIT at pc 0x8, memory latency 3:
  - The late response is discarded (fetch_valid stays 0).
  - The next imem_req has addr 0x100.
- redirect with redirect_pc=0x203 coinciding with imem_rvalid in WAIT:
  - fetch_valid=0 that cycle.
  - Next imem_addr is 0x200.
- Two redirects (0x40 then 0x80) while in DROP, before the stale response:
  - Exactly one request is outstanding.
  - Next imem_addr is 0x80.
- RESET_PC=32'hFFFF_FFFC, consume one instruction:
  - Next imem_addr is 0x0.
- rst asserted in WAIT:
  - Next cycle imem_addr=RESET_PC with imem_req=1.
  - A response arriving afterwards is ignored.
